// File: rtl/svf_cfg_pkg.sv
// Shared opcodes, status codes and FSM state type for the SVF configuration responder.
package svf_cfg_pkg;

    localparam logic [7:0] CFG_OP_SET    = 8'h01;
    localparam logic [7:0] CFG_OP_GET    = 8'h02;

    localparam logic [7:0] CFG_ST_OK     = 8'h00;
    localparam logic [7:0] CFG_ST_BADKEY = 8'h01;
    localparam logic [7:0] CFG_ST_UNSET  = 8'h02;

    typedef enum logic [1:0] {
        IDLE,
        KEY,
        VAL,
        RSP
    } cfg_state_e;

endpackage

// File: rtl/svf_cfg_table.sv
// Key-indexed table of 32-bit configuration values with per-entry written flags.
module svf_cfg_table #(
    parameter int unsigned NUM_KEYS = 16,
    parameter int unsigned KEY_W    = $clog2(NUM_KEYS)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [KEY_W-1:0]         wr_key,
    input  logic [31:0]              wr_data,
    input  logic [KEY_W-1:0]         rd_key,
    output logic [31:0]              rd_data,
    output logic                     rd_set,
    output logic [NUM_KEYS*32-1:0]   cfg_q,
    output logic [NUM_KEYS-1:0]      cfg_set
);

    logic [31:0]         mem_q [NUM_KEYS];
    logic [NUM_KEYS-1:0] set_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                mem_q[k] <= '0;
            end
            set_q <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (wr_key == KEY_W'(k)) begin
                    mem_q[k] <= wr_data;
                    set_q[k] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        cfg_q   = '0;
        rd_data = '0;
        rd_set  = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            cfg_q[32*k +: 32] = mem_q[k];
            if (rd_key == KEY_W'(k)) begin
                rd_data = mem_q[k];
                rd_set  = set_q[k];
            end
        end
    end

    assign cfg_set = set_q;

endmodule

// File: rtl/svf_cfg_responder.sv
// Parses framed SET/GET byte records, updates the config table and streams back responses.
module svf_cfg_responder
    import svf_cfg_pkg::*;
#(
    parameter int unsigned NUM_KEYS = 16,
    parameter int unsigned KEY_W    = $clog2(NUM_KEYS)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               rsp_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [NUM_KEYS*32-1:0]   cfg_q,
    output logic [NUM_KEYS-1:0]      cfg_set,
    output logic                     cfg_wr_stb,
    output logic [7:0]               err_cnt
);

    cfg_state_e       state_q, state_d;
    logic             is_set_q, is_set_d;
    logic [KEY_W-1:0] key_idx_q, key_idx_d;
    logic             key_ok_q, key_ok_d;
    logic [31:0]      val_q, val_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [39:0]      rsp_buf_q, rsp_buf_d;
    logic [2:0]       rsp_cnt_q, rsp_cnt_d;
    logic [7:0]       err_q, err_d;
    logic             stb_q;

    logic             accept;
    logic             key_ok_in;
    logic             wr_en;
    logic [31:0]      wr_data;
    logic [31:0]      rd_data;
    logic             rd_set;

    assign accept    = in_valid && in_ready;
    assign key_ok_in = (32'(in_data) < NUM_KEYS);
    assign wr_data   = {in_data, val_q[31:8]};

    svf_cfg_table #(
        .NUM_KEYS (NUM_KEYS),
        .KEY_W    (KEY_W)
    ) u_table (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_en),
        .wr_key  (key_idx_q),
        .wr_data (wr_data),
        .rd_key  (in_data[KEY_W-1:0]),
        .rd_data (rd_data),
        .rd_set  (rd_set),
        .cfg_q   (cfg_q),
        .cfg_set (cfg_set)
    );

    always_comb begin
        state_d   = state_q;
        is_set_d  = is_set_q;
        key_idx_d = key_idx_q;
        key_ok_d  = key_ok_q;
        val_d     = val_q;
        cnt_d     = cnt_q;
        rsp_buf_d = rsp_buf_q;
        rsp_cnt_d = rsp_cnt_q;
        err_d     = err_q;
        wr_en     = 1'b0;
        unique case (state_q)
            IDLE: if (accept) begin
                if (in_data == CFG_OP_SET || in_data == CFG_OP_GET) begin
                    is_set_d = (in_data == CFG_OP_SET);
                    state_d  = KEY;
                end else if (err_q != 8'hFF) begin
                    err_d = err_q + 8'd1;
                end
            end
            KEY: if (accept) begin
                key_idx_d = in_data[KEY_W-1:0];
                key_ok_d  = key_ok_in;
                if (is_set_q) begin
                    state_d = VAL;
                    cnt_d   = 2'd0;
                end else begin
                    // GET reads the table in the same cycle the key byte arrives.
                    state_d   = RSP;
                    rsp_cnt_d = 3'd5;
                    if (!key_ok_in) begin
                        rsp_buf_d = {32'h0, CFG_ST_BADKEY};
                    end else if (!rd_set) begin
                        rsp_buf_d = {32'h0, CFG_ST_UNSET};
                    end else begin
                        rsp_buf_d = {rd_data, CFG_ST_OK};
                    end
                end
            end
            VAL: if (accept) begin
                val_d = wr_data;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    wr_en     = key_ok_q;
                    rsp_buf_d = {32'h0, key_ok_q ? CFG_ST_OK : CFG_ST_BADKEY};
                    rsp_cnt_d = 3'd1;
                    state_d   = RSP;
                end
            end
            RSP: if (rsp_ready) begin
                rsp_buf_d = {8'h00, rsp_buf_q[39:8]};
                rsp_cnt_d = rsp_cnt_q - 3'd1;
                if (rsp_cnt_q == 3'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            is_set_q  <= 1'b0;
            key_idx_q <= '0;
            key_ok_q  <= 1'b0;
            val_q     <= '0;
            cnt_q     <= '0;
            rsp_buf_q <= '0;
            rsp_cnt_q <= '0;
            err_q     <= '0;
            stb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_set_q  <= is_set_d;
            key_idx_q <= key_idx_d;
            key_ok_q  <= key_ok_d;
            val_q     <= val_d;
            cnt_q     <= cnt_d;
            rsp_buf_q <= rsp_buf_d;
            rsp_cnt_q <= rsp_cnt_d;
            err_q     <= err_d;
            stb_q     <= wr_en;
        end
    end

    assign in_ready   = (state_q != RSP);
    assign rsp_valid  = (state_q == RSP);
    assign rsp_data   = rsp_buf_q[7:0];
    assign cfg_wr_stb = stb_q;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_svf_cfg_responder.sv
// Randomised bench for svf_cfg_responder: frame-level table/response model plus directed checks.
module tb_svf_cfg_responder;

    localparam int NK = 16;
    localparam int W  = NK * 32;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [7:0]     in_data = 8'h00;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [7:0]     rsp_data;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [W-1:0]   cfg_q;
    logic [NK-1:0]  cfg_set;
    logic           cfg_wr_stb;
    logic [7:0]     err_cnt;

    svf_cfg_responder #(.NUM_KEYS(NK)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rsp_data   (rsp_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .cfg_q      (cfg_q),
        .cfg_set    (cfg_set),
        .cfg_wr_stb (cfg_wr_stb),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_cyc = -5;
    int stb_cnt = 0;
    bit ready_mode = 1'b0;

    // Model: table contents, written flags, error count, expected response bytes.
    logic [31:0]  m_val [NK];
    bit           m_set [NK];
    int           m_err = 0;
    byte unsigned exp_q[$];
    byte unsigned got[$];
    int           got_cyc[$];

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] m_packed();
        logic [W-1:0] r;
        for (int k = 0; k < NK; k++) r[32*k +: 32] = m_val[k];
        return r;
    endfunction

    function automatic logic [NK-1:0] m_setv();
        logic [NK-1:0] r;
        for (int k = 0; k < NK; k++) r[k] = m_set[k];
        return r;
    endfunction

    function automatic logic [39:0] last5();
        int n;
        n = got.size();
        if (n < 5) return '1;
        return {got[n-5], got[n-4], got[n-3], got[n-2], got[n-1]};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cfg_wr_stb) stb_cnt <= stb_cnt + 1;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = ready_mode || ($urandom_range(0, 1) == 1);
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            check("rsp_valid", W'(rsp_valid), W'(exp_q.size() != 0));
            if (rsp_valid && exp_q.size() != 0) begin
                check("rsp_data", W'(rsp_data), W'(exp_q[0]));
                check("in_ready_in_rsp", W'(in_ready), W'(0));
                if (rsp_ready) begin
                    got.push_back(rsp_data);
                    got_cyc.push_back(cyc);
                    void'(exp_q.pop_front());
                end
            end else begin
                check("in_ready_idle", W'(in_ready), W'(1));
            end
            check("cfg_q", cfg_q, m_packed());
            check("cfg_set", W'(cfg_set), W'(m_setv()));
            check("err_cnt", W'(err_cnt), W'(m_err));
            check("cfg_wr_stb", W'(cfg_wr_stb), W'(cyc == wr_cyc));
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_set(input int key, input logic [31:0] v);
        send_byte(8'h01);
        send_byte(8'(key));
        send_byte(v[7:0]);
        send_byte(v[15:8]);
        send_byte(v[23:16]);
        send_byte(v[31:24]);
        if (key < NK) begin
            m_val[key] = v;
            m_set[key] = 1'b1;
            wr_cyc = cyc;
            exp_q.push_back(8'h00);
        end else begin
            exp_q.push_back(8'h01);
        end
    endtask

    task automatic do_get(input int key);
        logic [31:0] v;
        send_byte(8'h02);
        send_byte(8'(key));
        if (key >= NK) begin
            exp_q.push_back(8'h01);
            v = 32'h0;
        end else if (!m_set[key]) begin
            exp_q.push_back(8'h02);
            v = 32'h0;
        end else begin
            exp_q.push_back(8'h00);
            v = m_val[key];
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
    endtask

    task automatic do_junk(input logic [7:0] b);
        send_byte(b);
        if (m_err < 255) m_err++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rsp_timeout: got %0d pending bytes expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn     = 1'b0;
        in_valid = 1'b0;
        #1;
        for (int k = 0; k < NK; k++) begin
            m_val[k] = 32'h0;
            m_set[k] = 1'b0;
        end
        m_err  = 0;
        wr_cyc = -5;
        exp_q.delete();
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_rsp_valid", W'(rsp_valid), W'(0));
        check("rst_rsp_data", W'(rsp_data), W'(0));
        check("rst_cfg_q", cfg_q, W'(0));
        check("rst_cfg_set", W'(cfg_set), W'(0));
        check("rst_wr_stb", W'(cfg_wr_stb), W'(0));
        check("rst_err_cnt", W'(err_cnt), W'(0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n0;
        logic [7:0] b;

        do_reset();
        repeat (2) @(negedge clk);

        s0 = stb_cnt;
        do_set(2, 32'hDEADBEEF);
        wait_idle();
        check("set2_status", W'(got[got.size()-1]), W'(8'h00));
        check("set2_cfg_q", W'(cfg_q[95:64]), W'(32'hDEADBEEF));
        check("set2_cfg_set", W'(cfg_set[2]), W'(1));
        check("set2_stb_pulses", W'(stb_cnt - s0), W'(1));

        do_get(2);
        wait_idle();
        check("get2_rsp", W'(last5()), W'(40'h00_EF_BE_AD_DE));
        do_get(5);
        wait_idle();
        check("get5_rsp", W'(last5()), W'(40'h02_00_00_00_00));

        s0 = stb_cnt;
        do_set(20, 32'h11223344);
        wait_idle();
        check("set20_status", W'(got[got.size()-1]), W'(8'h01));
        check("set20_no_stb", W'(stb_cnt - s0), W'(0));
        do_get(20);
        wait_idle();
        check("get20_rsp", W'(last5()), W'(40'h01_00_00_00_00));

        do_junk(8'h7F);
        do_junk(8'h00);
        do_junk(8'h7F);
        do_get(2);
        wait_idle();
        check("junk3_err_cnt", W'(err_cnt), W'(3));
        check("junk3_get2_rsp", W'(last5()), W'(40'h00_EF_BE_AD_DE));

        ready_mode = 1'b1;
        @(negedge clk);
        n0 = got.size();
        do_get(2);
        wait_idle();
        check("burst_span", W'(got_cyc[n0+4] - got_cyc[n0]), W'(4));
        ready_mode = 1'b0;

        send_byte(8'h01);
        send_byte(8'h03);
        send_byte(8'hAA);
        do_reset();
        do_set(3, 32'h12345678);
        wait_idle();
        check("post_rst_status", W'(got[got.size()-1]), W'(8'h00));
        check("post_rst_cfg_q3", W'(cfg_q[127:96]), W'(32'h12345678));

        do_get(3);
        @(negedge clk);
        do_reset();
        repeat (4) @(negedge clk);

        for (int i = 0; i < 80; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) begin
                do_set($urandom_range(0, 19), $urandom);
            end else if (r < 8) begin
                do_get($urandom_range(0, 19));
            end else begin
                b = 8'($urandom);
                if (b == 8'h01 || b == 8'h02) b = 8'h80;
                do_junk(b);
            end
        end
        wait_idle();

        for (int i = 0; i < 300; i++) begin
            do_junk(8'hC3);
        end
        @(negedge clk);
        check("err_cnt_saturated", W'(err_cnt), W'(8'hFF));

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
